// File: rtl/prog_loader.sv
// UART program loader: receives a length-prefixed big-endian word stream,
// writes it into instruction memory and answers the host with an ACK byte.
module prog_loader #(
    parameter int          ADDR_W   = 15,
    parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_ferr,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err,
    output logic [31:0]       word_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ACK  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

    logic [2:0]      state;
    logic [1:0]      byte_cnt;
    logic [23:0]     asm_word;
    logic [ADDR_W:0] word_idx;

    logic            accept;
    logic            bad;
    logic [31:0]     len_next;
    logic [31:0]     asm_next;
    logic [ADDR_W:0] idx_next;
    logic            last_wr;

    assign accept   = rx_valid & ~rx_ferr;
    assign bad      = rx_valid & rx_ferr;
    assign len_next = {word_count[23:0], rx_data};
    assign asm_next = {asm_word, rx_data};
    assign idx_next = word_idx + 1'b1;
    // The write pulse currently on the bus is the final word of the load.
    assign last_wr  = imem_we && (idx_next == word_count[ADDR_W:0]);

    // ACK is only entered a cycle after the last write, so this never
    // coincides with imem_we.
    assign tx_start = (state == S_ACK) && !tx_busy;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            byte_cnt   <= 2'd0;
            asm_word   <= 24'd0;
            word_idx   <= '0;
            tx_data    <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LEN;
                        byte_cnt   <= 2'd0;
                        word_idx   <= '0;
                        word_count <= 32'd0;
                    end
                end
                S_LEN: begin
                    if (bad) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else if (accept) begin
                        word_count <= len_next;
                        byte_cnt   <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (len_next == 32'd0) begin
                                state   <= S_ACK;
                                tx_data <= ACK_BYTE;
                            end else if ({1'b0, len_next} > MAX_WORDS) begin
                                state <= S_ERR;
                                err   <= 1'b1;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (bad) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else begin
                        if (accept) begin
                            asm_word <= asm_next[23:0];
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3 && !last_wr) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_idx[ADDR_W-1:0];
                                imem_wdata <= asm_next;
                            end
                        end
                        if (imem_we) begin
                            word_idx <= idx_next;
                            if (last_wr) begin
                                state   <= S_ACK;
                                tx_data <= ACK_BYTE;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (!tx_busy) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: state <= S_DONE;
                S_ERR:  state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte streams in, imem writes and ACK
// observed on the falling edge against hand-computed values.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ferr = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        imem_we;
    logic [14:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        done;
    logic        err;
    logic [31:0] word_count;

    prog_loader dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ferr    (rx_ferr),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_chk = 0;
    int          n_err = 0;
    int          we_cnt = 0;
    int          tx_cnt = 0;
    int          bad_tx = 0;
    int          we_cyc = 0;
    int          tx_cyc = 0;
    int          done_cyc = 0;
    int          last_cyc = 0;
    logic        done_q = 1'b0;
    logic [7:0]  tx_byte = 8'd0;
    logic [14:0] we_addr [0:15];
    logic [31:0] we_data [0:15];

    always @(negedge clk) begin
        if (imem_we) begin
            if (we_cnt < 16) begin
                we_addr[we_cnt] = imem_addr;
                we_data[we_cnt] = imem_wdata;
            end
            we_cyc = cyc;
            we_cnt++;
        end
        if (tx_start) begin
            tx_cnt++;
            tx_byte = tx_data;
            tx_cyc = cyc;
            if (tx_busy) bad_tx++;
        end
        if (done && !done_q) done_cyc = cyc;
        done_q = done;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic fe);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        rx_ferr  = fe;
        last_cyc = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24], 1'b0);
        send(w[23:16], 1'b0);
        send(w[15:8], 1'b0);
        send(w[7:0], 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn    = 1'b0;
        start   = 1'b0;
        tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || err) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done | err}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    int w0, t0;
    int rel;

    initial begin
        // reset values
        do_reset();
        @(negedge clk);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {17'd0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_count", word_count, 32'd0);

        // two-word load with latency checks
        w0 = we_cnt; t0 = tx_cnt;
        start = 1'b1;
        send_word(32'h0000_0002);
        send_word(32'h1234_5678);
        send_word(32'h9ABC_DEF0);
        wait_end("t1_timeout");
        check("t1_we_cnt", we_cnt - w0, 2);
        check("t1_addr0", {17'd0, we_addr[w0]}, 32'd0);
        check("t1_data0", we_data[w0], 32'h1234_5678);
        check("t1_addr1", {17'd0, we_addr[w0+1]}, 32'd1);
        check("t1_data1", we_data[w0+1], 32'h9ABC_DEF0);
        check("t1_tx_cnt", tx_cnt - t0, 1);
        check("t1_tx_byte", {24'd0, tx_byte}, 32'hAA);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_err", {31'd0, err}, 32'd0);
        check("t1_count", word_count, 32'd2);
        check("t1_we_lat", we_cyc - last_cyc, 1);
        check("t1_tx_lat", {31'd0, (tx_cyc - last_cyc) >= 2}, 32'd1);
        check("t1_done_lat", done_cyc - tx_cyc, 1);
        start = 1'b0;
        send(8'h55, 1'b0);
        send_word(32'h0102_0304);
        check("t1_post_we", we_cnt - w0, 2);
        check("t1_post_tx", tx_cnt - t0, 1);
        check("t1_post_done", {31'd0, done}, 32'd1);

        // zero-length load
        do_reset();
        w0 = we_cnt; t0 = tx_cnt;
        start = 1'b1;
        send_word(32'h0000_0000);
        wait_end("t2_timeout");
        check("t2_we_cnt", we_cnt - w0, 0);
        check("t2_tx_cnt", tx_cnt - t0, 1);
        check("t2_tx_byte", {24'd0, tx_byte}, 32'hAA);
        check("t2_done", {31'd0, done}, 32'd1);

        // N = 2**15 is legal: block waits for data, no error
        do_reset();
        start = 1'b1;
        send_word(32'h0000_8000);
        repeat (5) @(negedge clk);
        check("t3_max_err", {31'd0, err}, 32'd0);
        check("t3_max_done", {31'd0, done}, 32'd0);

        // N = 2**15 + 1 is rejected
        do_reset();
        w0 = we_cnt; t0 = tx_cnt;
        start = 1'b1;
        send_word(32'h0000_8001);
        wait_end("t3_timeout");
        check("t3_err", {31'd0, err}, 32'd1);
        check("t3_we_cnt", we_cnt - w0, 0);
        check("t3_tx_cnt", tx_cnt - t0, 0);
        check("t3_done", {31'd0, done}, 32'd0);

        // framing error mid-word
        do_reset();
        w0 = we_cnt; t0 = tx_cnt;
        start = 1'b1;
        send_word(32'h0000_0001);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        wait_end("t4_timeout");
        send(8'h44, 1'b0);
        send_word(32'h5566_7788);
        check("t4_err", {31'd0, err}, 32'd1);
        check("t4_we_cnt", we_cnt - w0, 0);
        check("t4_tx_cnt", tx_cnt - t0, 0);

        // transmitter busy for 50 cycles; start dropped mid-load
        do_reset();
        w0 = we_cnt; t0 = tx_cnt;
        start = 1'b1;
        send_word(32'h0000_0001);
        start   = 1'b0;
        tx_busy = 1'b1;
        send_word(32'h0BAD_F00D);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("t5_busy_tx", tx_cnt - t0, 0);
        check("t5_busy_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        tx_busy = 1'b0;
        rel = cyc;
        wait_end("t5_timeout");
        check("t5_we_cnt", we_cnt - w0, 1);
        check("t5_data", we_data[w0], 32'h0BAD_F00D);
        check("t5_tx_cnt", tx_cnt - t0, 1);
        check("t5_tx_cyc", tx_cyc - rel, 0);
        check("t5_bad_tx", bad_tx, 0);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_done_lat", done_cyc - tx_cyc, 1);

        // reset mid-word, then a fresh one-word load
        do_reset();
        w0 = we_cnt; t0 = tx_cnt;
        start = 1'b1;
        send_word(32'h0000_0001);
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        do_reset();
        @(negedge clk);
        check("t6_rst_count", word_count, 32'd0);
        start = 1'b1;
        send_word(32'h0000_0001);
        send_word(32'hCAFE_BABE);
        wait_end("t6_timeout");
        check("t6_we_cnt", we_cnt - w0, 1);
        check("t6_addr", {17'd0, we_addr[w0]}, 32'd0);
        check("t6_data", we_data[w0], 32'hCAFE_BABE);
        check("t6_done", {31'd0, done}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 15, instruction-memory word-address width.
REQ-002 Parameter ACK_BYTE, default 8'hAA, byte sent when a load completes.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  level; high while the CPU is in its load mode.
REQ-006 rx_data  input  8  received UART byte.
REQ-007 rx_valid  input  1  one-cycle pulse; rx_data is valid this cycle.
REQ-008 rx_ferr  input  1  framing error for the byte flagged by rx_valid.
REQ-009 tx_busy  input  1  UART transmitter busy.
REQ-010 tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
REQ-011 tx_data  output  8  byte to transmit.
REQ-012 imem_we  output  1  instruction-memory write enable, one cycle per word.
REQ-013 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-014 imem_wdata  output  32  instruction word to write.
REQ-015 done  output  1  level; the load and the ACK have completed.
REQ-016 err  output  1  level; the load was aborted.
REQ-017 word_count  output  32  length header received from the host.

Function
REQ-018 States: IDLE, LEN, DATA, ACK, DONE, ERR.
REQ-019 Stream format: a 4-byte big-endian word count N, then N words of 4 bytes each, big-endian (first byte goes to bits [31:24]).
REQ-020 A byte is accepted only when rx_valid=1 and rx_ferr=0; a byte with rx_ferr=1 moves the block to ERR.
REQ-021 IDLE: stays in IDLE while start=0; moves to LEN on the first cycle start=1; byte counter and word address cleared to 0.
REQ-022 LEN: shifts accepted bytes into word_count; after the 4th byte, goes to DATA if 0<N<=2**ADDR_W, to ACK if N=0, and to ERR if N>2**ADDR_W.
REQ-023 DATA: shifts bytes into a 32-bit assembly register, using a 2-bit byte counter that wraps 3->0.
REQ-024 On the cycle after the 4th byte of a word is accepted, imem_we=1 for exactly one cycle, with imem_addr = the current word index and imem_wdata = the assembled word.
REQ-025 The word index starts at 0 and increments by 1 after each write.
REQ-026 After the write for index N-1, the block goes to ACK; no further imem_we pulses occur for the rest of the load.
REQ-027 Bytes accepted in ACK, DONE or ERR are ignored.
REQ-028 ACK: when tx_busy=0, drives tx_start=1 for one cycle with tx_data=ACK_BYTE, then goes to DONE; while tx_busy=1, it waits with tx_start=0.
REQ-029 DONE: done=1 and the block stays in DONE until reset; start is ignored.
REQ-030 ERR: err=1, no imem writes, no ACK; the block stays in ERR until reset.
REQ-031 A deassertion of start after leaving IDLE is ignored; the load continues.
REQ-032 tx_start and imem_we are never asserted in the same cycle as each other's state transition; a pulse is never longer than one cycle.
REQ-033 Latency: the last byte of the final word -> imem_we 1 cycle later -> tx_start no earlier than 2 cycles after that byte (when tx_busy=0) -> done the cycle after tx_start.

Reset
REQ-034 While rstn=0 at a clock edge, the state goes to IDLE.
REQ-035 Reset values: tx_start=0, tx_data=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err=0, word_count=0, byte counter=0.
REQ-036 A reset in mid-load discards the partial word and the count; the next load restarts at address 0.

Verification
REQ-037 start=1; bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 -> imem_we pulses with (addr 0, 0x12345678) and then (addr 1, 0x9ABCDEF0); tx_start once with 0xAA; done=1; word_count=2.
REQ-038 Header 00 00 00 00 -> no imem_we; tx_start with 0xAA; done=1.
REQ-039 Header with N = 2**ADDR_W + 1 -> err=1; no imem_we; no tx_start; done stays 0.
REQ-040 Byte with rx_ferr=1 during DATA -> err=1; no write of the partial word.
REQ-041 tx_busy held at 1 for 50 cycles after the last write -> tx_start stays 0 during those cycles, asserts on the first cycle tx_busy=0, then done=1.
REQ-042 rstn=0 after 2 bytes of word 0, then a full 1-word load -> single imem_we at addr 0 with the new word; done=1.
